// File: rtl/freq_period_meter.sv
// freq_period_meter: measures high/low phase lengths of SigIn (divider output) in Clk cycles.
// Latency: Valid one cycle after s0 shows the closing rise; s0 trails SigIn by 1 cycle (3 with sync).
// Backpressure: none; results are overwritten each period, Valid/Timeout are one-cycle strobes.
// Build macro FREQ_PERIOD_METER_SYNC_EN inserts a two-flop synchronizer ahead of s0.
module freq_period_meter #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             SigIn,
  input  logic             Start,
  input  logic             Continuous,
  output logic [CNT_W-1:0] HighCnt,
  output logic [CNT_W-1:0] LowCnt,
  output logic [CNT_W-1:0] Period,
  output logic             Valid,
  output logic             Busy,
  output logic             Timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [31:0]      WD_LIMIT = 32'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  state_t           state;
  logic             sig_sync;
  logic             s0;
  logic             prev;
  logic             rise;
  logic             fall;
  logic             any_edge;
  logic             expire;
  logic [31:0]      wd_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic [CNT_W:0]   period_sum;
  logic [CNT_W-1:0] period_sat;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

`ifdef FREQ_PERIOD_METER_SYNC_EN
  logic sync_a;
  logic sync_b;

  // Two-flop synchronizer: the divider output may toggle on either Clk edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= SigIn;
      sync_b <= sync_a;
    end
  end

  assign sig_sync = sync_b;
`else
  assign sig_sync = SigIn;
`endif

  // Sample register s0 and its one-cycle-delayed copy for edge detection.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s0   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s0   <= sig_sync;
      prev <= s0;
    end
  end

  assign rise     = s0 & ~prev;
  assign fall     = ~s0 & prev;
  assign any_edge = rise | fall;
  // An edge in the expiry cycle wins, so expiry requires a quiet cycle.
  assign expire   = ~any_edge & (wd_cnt == WD_LIMIT);

  // Period is summed one bit wider so saturation is independent of the phase counters.
  assign period_sum = {1'b0, high_cnt} + {1'b0, low_cnt};
  assign period_sat = period_sum[CNT_W] ? CNT_MAX : period_sum[CNT_W-1:0];

  // Measurement FSM with watchdog; all outputs are registered here.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      wd_cnt   <= '0;
      high_cnt <= '0;
      low_cnt  <= '0;
      HighCnt  <= '0;
      LowCnt   <= '0;
      Period   <= '0;
      Valid    <= 1'b0;
      Busy     <= 1'b0;
      Timeout  <= 1'b0;
    end else begin
      Valid   <= 1'b0;
      Timeout <= 1'b0;
      if (state == IDLE) begin
        if (Start) begin
          state  <= ARM;
          Busy   <= 1'b1;
          wd_cnt <= '0;
        end
      end else if (expire) begin
        // Watchdog abort: results stay at their previous values.
        state   <= IDLE;
        Busy    <= 1'b0;
        Timeout <= 1'b1;
      end else begin
        wd_cnt <= any_edge ? 32'd0 : wd_cnt + 32'd1;
        case (state)
          ARM: begin
            // Only a genuine rise starts a period, so a partial high phase is skipped.
            if (rise) begin
              state    <= HIGH;
              high_cnt <= CNT_W'(1);
            end
          end
          HIGH: begin
            if (fall) begin
              state   <= LOW;
              low_cnt <= CNT_W'(1);
            end else if (s0) begin
              high_cnt <= sat_inc(high_cnt);
            end
          end
          LOW: begin
            if (rise) begin
              HighCnt <= high_cnt;
              LowCnt  <= low_cnt;
              Period  <= period_sat;
              Valid   <= 1'b1;
              if (Continuous) begin
                // The closing rise is the first high cycle of the next period.
                state    <= HIGH;
                high_cnt <= CNT_W'(1);
              end else begin
                state <= IDLE;
                Busy  <= 1'b0;
              end
            end else if (!s0) begin
              low_cnt <= sat_inc(low_cnt);
            end
          end
          default: begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/freq_period_meter.md
# freq_period_meter

Measures the divided clock produced by the frequency divider stage. It samples the divider output `SigIn` on `Clk` and counts the high-phase and low-phase lengths of one full period in `Clk` cycles. It reports the result with a one-cycle `Valid` strobe. A watchdog reports a stalled or disabled divider, and an optional continuous mode re-arms after every period.

## Interface
- `CNT_W`, default 32: width of the high, low and period counters.
- `TIMEOUT_CYC`, default 65535: number of `Clk` cycles without an edge on `SigIn` before a timeout, 1..2^32-1.
- `Clk`  input  1  sole clock; every register updates on its rising edge.
- `Reset`  input  1  synchronous, active-high reset.
- `SigIn`  input  1  divided clock from the divider stage (`ClkOut`).
- `Start`  input  1  single-cycle request to begin a measurement; sampled in IDLE only.
- `Continuous`  input  1  when 1, re-arm automatically after each completed period.
- `HighCnt`  output  CNT_W  high-phase length of the last completed period.
- `LowCnt`  output  CNT_W  low-phase length of the last completed period.
- `Period`  output  CNT_W  HighCnt+LowCnt, saturated at 2^CNT_W-1.
- `Valid`  output  1  one-cycle pulse; the three results above were updated this cycle.
- `Busy`  output  1  high in ARM, HIGH and LOW.
- `Timeout`  output  1  one-cycle pulse; watchdog expired and the measurement was aborted.

## Operation
- Sampling: `s0` is `SigIn` registered once and `prev` is `s0` delayed one cycle.
  - rise = s0 & ~prev
  - fall = ~s0 & prev
- FSM states: IDLE, ARM, HIGH, LOW.
  - IDLE: `Start`=1 goes to ARM and clears the watchdog.
  - ARM: rise goes to HIGH with high counter = 1. Any time the sampled signal is already high, the FSM waits for the next rise, so a partial phase is never measured.
  - HIGH: s0=1 increments the high counter; fall goes to LOW with low counter = 1.
  - LOW: s0=0 increments the low counter. On rise:
    - latch HighCnt, LowCnt and Period, and pulse `Valid`;
    - if `Continuous`=1, go to HIGH with high counter = 1; the closing rise is the first high cycle of the next period;
    - else go to IDLE.
- Counters saturate at 2^CNT_W-1 and never wrap. Period saturates independently.
- Watchdog: counts cycles in ARM, HIGH and LOW, and clears on every rise or fall.
  - When it reaches `TIMEOUT_CYC`, pulse `Timeout`, go to IDLE, and leave the result outputs unchanged.
  - If an edge arrives in the same cycle the watchdog would expire, the edge wins and no timeout occurs.
- `Start` outside IDLE is ignored. `Continuous` is sampled only at the closing rise.
- `Valid` and `Timeout` are never high in the same cycle.

## Timing
- Reset values:
  - HighCnt = LowCnt = Period = 0
  - Valid = Busy = Timeout = 0
  - FSM in IDLE; `s0`, `prev` and all counters 0.
- `Reset` has priority over every other input, including `Start` in the same cycle.
- `Reset` mid-measurement aborts on the next edge with no `Valid` and no `Timeout`.
- Input latency: an edge on `SigIn` appears in `s0` one `Clk` later.
- `Valid` is asserted in the cycle after the edge at which `s0` first shows the closing rise, and lasts exactly one cycle. The result outputs change only in that cycle.
- `Busy` rises the cycle after `Start` is accepted. It falls together with the `Valid` or `Timeout` pulse when returning to IDLE.
- Minimum measurable phase is 1 cycle; high=1 and low=1 gives Period=2.
- `Timeout` is asserted `TIMEOUT_CYC`+1 cycles after the last watchdog clear, including the `Start` acceptance.

## Configuration
- `FREQ_PERIOD_METER_SYNC_EN`
  - Defined: two extra flops precede `s0` as a metastability synchronizer, because the divider output can change on either `Clk` edge. Input latency becomes 3 cycles and all other latencies shift by +2.
  - Undefined: `s0` is a single register, latency 1 cycle.
- Counted values are identical in both builds.

## Test plan
- Reset, then `SigIn` high 3 / low 5 repeating, `Start` pulse, `Continuous`=0: one `Valid` with HighCnt=3, LowCnt=5, Period=8; then `Busy`=0 and no further `Valid`.
- Same stimulus with `Continuous`=1: a `Valid` every 8 cycles, each with 3/5/8 and no missed periods. Dropping `Continuous` ends the run after the current period.
- `Start` while `SigIn` is mid-high: first result is a full period, not partial. For 4/4 the first `Valid` is 4/4/8.
- `SigIn` held at 0 with `TIMEOUT_CYC`=16: `Timeout` pulses once after 17 cycles. Results keep their prior values and `Valid` stays 0.
- `Reset` asserted during LOW: next cycle all outputs are 0, FSM in IDLE, and no `Valid` is ever issued for the aborted period.
- `CNT_W`=4 with high 20 / low 2: HighCnt=15 (saturated), LowCnt=2, Period=15 (saturated).
